// File: rtl/in3_pattern_gen_if.sv
// rtl/in3_pattern_gen_if.sv - control/pattern bundle for in3_pattern_gen
// PATTERN_CHECK_EN adds the OR-gate return path and checker results.
interface in3_pattern_gen_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
`ifdef PATTERN_CHECK_EN
  logic       or_in;
  logic [3:0] err_cnt;
  logic       pass;

  modport master (input start, input or_in,
                  output a, output b, output c, output busy, output done,
                  output err_cnt, output pass);
  modport slave  (output start, output or_in,
                  input a, input b, input c, input busy, input done,
                  input err_cnt, input pass);
`else
  modport master (input start,
                  output a, output b, output c, output busy, output done);
  modport slave  (output start,
                  input a, input b, input c, input busy, input done);
`endif
endinterface

// File: rtl/in3_pattern_gen.sv
// rtl/in3_pattern_gen.sv - sweeps {a,b,c} through 000..111, HOLD_CYCLES clocks each
// Optional OR-gate response checker enabled by PATTERN_CHECK_EN.
module in3_pattern_gen #(
  parameter int HOLD_CYCLES = 10
) (
  input logic              clk,
  input logic              rst_n,
  in3_pattern_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] pat_q, pat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       window_end;

`ifdef PATTERN_CHECK_EN
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
`endif

  assign window_end = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PATTERN_CHECK_EN
    err_d   = err_q;
    pass_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          hold_d  = 8'd0;
          pat_d   = 3'd0;
`ifdef PATTERN_CHECK_EN
          err_d   = 4'd0;
`endif
        end
      end
      RUN: begin
`ifdef PATTERN_CHECK_EN
        // The gate response is judged once, at the end of each hold window.
        if (window_end && (bus.or_in != (|pat_q)) && (err_q != 4'd8)) begin
          err_d = err_q + 4'd1;
        end
`endif
        if (window_end) begin
          hold_d = 8'd0;
          if (pat_q == 3'd7) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pat_d   = 3'd0;
`ifdef PATTERN_CHECK_EN
            pass_d  = (err_d == 4'd0);
`endif
          end else begin
            pat_d = pat_q + 3'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        pat_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      pat_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATTERN_CHECK_EN
      err_q   <= 4'd0;
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PATTERN_CHECK_EN
      err_q   <= err_d;
      pass_q  <= pass_d;
`endif
    end
  end

  assign bus.a    = pat_q[2];
  assign bus.b    = pat_q[1];
  assign bus.c    = pat_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef PATTERN_CHECK_EN
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;
`endif

endmodule

// File: tb/tb_in3_pattern_gen.sv
// tb/tb_in3_pattern_gen.sv - scoreboard bench for in3_pattern_gen (HOLD_CYCLES 10 and 1)
// Honours PATTERN_CHECK_EN when defined.
module tb_in3_pattern_gen;

  typedef struct packed {
    logic [2:0] pat;
    logic       busy;
    logic       done;
    logic [3:0] err;
    logic       pass;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stuck = 1'b0;

  int total = 0;
  int bad   = 0;
  int runs_exp [2] = '{0, 0};
  int runs_seen[2] = '{0, 0};
  int qlen     [2] = '{0, 0};

  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, inst, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int H = (g == 0) ? 10 : 1;

    in3_pattern_gen_if bus();
    rec_t q[$];

    assign bus.start = start;
`ifdef PATTERN_CHECK_EN
    assign bus.or_in = stuck ? 1'b0 : (bus.a | bus.b | bus.c);
`endif

    in3_pattern_gen #(.HOLD_CYCLES(H)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    // Reference: an accepted start yields 8*H pattern cycles then one DONE cycle.
    initial begin : model
      int   remain;
      rec_t r;
      remain = 0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          if (q.size() != 0) runs_exp[g]--;
          q.delete();
          remain = 0;
        end else if (remain == 0) begin
          if (start) begin
            for (int i = 0; i < 8 * H; i++) begin
              r      = '0;
              r.pat  = 3'(i / H);
              r.busy = 1'b1;
`ifdef PATTERN_CHECK_EN
              if (stuck && (i / H) > 1) r.err = 4'((i / H) - 1);
`endif
              q.push_back(r);
            end
            r      = '0;
            r.done = 1'b1;
`ifdef PATTERN_CHECK_EN
            r.err  = stuck ? 4'd7 : 4'd0;
            r.pass = !stuck;
`endif
            q.push_back(r);
            remain = 8 * H + 1;
            runs_exp[g]++;
          end
        end else begin
          remain--;
        end
        qlen[g] = q.size();
      end
    end

    initial begin : monitor
      rec_t act;
      rec_t want;
      forever begin
        @(negedge clk);
        act      = '0;
        act.pat  = {bus.a, bus.b, bus.c};
        act.busy = bus.busy;
        act.done = bus.done;
`ifdef PATTERN_CHECK_EN
        act.err  = bus.err_cnt;
        act.pass = bus.pass;
`endif
        if (!rst_n) begin
          check(g, "reset_state", 32'(act), 32'd0);
        end else if (bus.busy || bus.done) begin
          if (q.size() == 0) begin
            check(g, "unexpected_output", 32'(act), 32'd0);
          end else begin
            want = q.pop_front();
            qlen[g] = q.size();
            check(g, "sweep", 32'(act), 32'(want));
            if (bus.done) runs_seen[g]++;
          end
        end else begin
          check(g, "idle_outputs", 32'({act.pat, act.busy, act.done}), 32'd0);
          check(g, "idle_queue_empty", 32'(q.size()), 32'd0);
        end
      end
    end
  end

  task automatic cyc(input logic s);
    @(negedge clk);
    start = s;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) cyc(1'b0);
    #2 rst_n = 1'b1;

    // Single run with stray starts during RUN (E0+5) and DONE (E0+81).
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    repeat (75) cyc(1'b0);
    cyc(1'b1);
    repeat (100) cyc(1'b0);

    // start held high: back-to-back runs separated by one IDLE cycle.
    repeat (30) cyc(1'b1);
    repeat (100) cyc(1'b0);

    // Reset in the middle of pattern 011, then a full sweep.
    cyc(1'b1);
    repeat (35) cyc(1'b0);
    pulse_reset();
    cyc(1'b1);
    repeat (100) cyc(1'b0);

    // OR return stuck low, twice, so the second start must clear the count.
    stuck = 1'b1;
    cyc(1'b1);
    repeat (100) cyc(1'b0);
    cyc(1'b1);
    repeat (100) cyc(1'b0);
    stuck = 1'b0;
    cyc(1'b1);
    repeat (100) cyc(1'b0);

    for (int seg = 0; seg < 10; seg++) begin
      stuck = 1'($urandom_range(0, 1));
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 299) == 0) pulse_reset();
        else cyc(1'($urandom_range(0, 15) == 0));
      end
      repeat (100) cyc(1'b0);
    end

    for (int g = 0; g < 2; g++) begin
      check(g, "done_pulse_count", 32'(runs_seen[g]), 32'(runs_exp[g]));
      check(g, "final_queue_empty", 32'(qlen[g]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in3_pattern_gen.md
IN3_PATTERN_GEN -- requirements
Module: in3_pattern_gen

Interface
REQ-001 Parameter: HOLD_CYCLES, default 10, clock cycles each input pattern is held; legal range 1..255.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  run request; sampled only in IDLE.
REQ-005 Port: a  output  1  pattern bit 2 (MSB); drives 3-input OR gate input a.
REQ-006 Port: b  output  1  pattern bit 1; drives OR gate input b.
REQ-007 Port: c  output  1  pattern bit 0 (LSB); drives OR gate input c.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse when the sweep completes.
REQ-010 Port (PATTERN_CHECK_EN only): or_in  input  1  OR gate output returned for checking.
REQ-011 Port (PATTERN_CHECK_EN only): err_cnt  output  4  count of mismatched patterns in the last run.
REQ-012 Port (PATTERN_CHECK_EN only): pass  output  1  high when done=1 and err_cnt=0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE; encoding is free.
REQ-014 In IDLE: a=b=c=0, busy=0, done=0.
REQ-015 IDLE->RUN on a rising edge with start=1; the edge that samples start is E0.
REQ-016 After E0: busy=1, {a,b,c}=3'b000, hold counter=0.
REQ-017 Each pattern SHALL stay stable for exactly HOLD_CYCLES cycles; {a,b,c} becomes pattern k after edge E0+k*HOLD_CYCLES, k=0..7, in ascending binary order 000->111.
REQ-018 After edge E0+8*HOLD_CYCLES: state=DONE, busy=0, done=1, {a,b,c}=000.
REQ-019 DONE->IDLE unconditionally on the next edge; done is high for exactly one cycle.
REQ-020 start SHALL be ignored in RUN and DONE; it is not queued.
REQ-021 start held high continuously restarts a run from the first IDLE cycle after DONE, i.e. one IDLE cycle separates runs.
REQ-022 HOLD_CYCLES=1: pattern advances every cycle; RUN lasts 8 cycles.
REQ-023 All outputs SHALL be registered; no combinational path from start or or_in to any output.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE: a=b=c=0, busy=0, done=0, hold counter=0, err_cnt=0, pass=0, regardless of clk.
REQ-025 Reset asserted mid-RUN aborts the run; no done pulse is produced.
REQ-026 After rst_n deasserts, the block waits in IDLE for start.

Configuration
REQ-027 Macro PATTERN_CHECK_EN defined: or_in, err_cnt and pass ports exist and the checker is present.
REQ-028 With the checker present, or_in is sampled on the last cycle of each pattern's hold window and compared with a|b|c; each mismatch increments err_cnt by 1 (max 8, no wrap).
REQ-029 err_cnt clears to 0 on the edge that accepts start and holds its value from DONE until the next accepted start.
REQ-030 pass = 1 only during the DONE cycle with err_cnt=0.
REQ-031 Macro undefined: those three ports and all checker logic are absent; all other behaviour is identical.

Verification
REQ-032 HOLD_CYCLES=10, start pulse at E0 -> {a,b,c} = 000,001,...,111, 10 cycles each; done high exactly at cycle E0+80; busy high for 80 cycles.
REQ-033 HOLD_CYCLES=1, start held high -> 8-cycle sweep, 1 DONE cycle, 1 IDLE cycle, then the second run begins at E0+10.
REQ-034 rst_n pulled low at cycle E0+35 (pattern 011) -> outputs 000 and busy 0 immediately; no done pulse; a later start runs a full sweep.
REQ-035 PATTERN_CHECK_EN, or_in wired to a correct OR gate -> err_cnt=0 and pass=1 in the DONE cycle.
REQ-036 PATTERN_CHECK_EN, or_in stuck at 0 -> err_cnt=7 and pass=0 in DONE; the next start clears err_cnt to 0.
REQ-037 start pulses during RUN at E0+5 and during DONE -> no effect on pattern timing or done timing.
